// File: rtl/bus_mult16_if.sv
// bus_mult16_if: CPU-side register access bus for the bus_mult16 peripheral.
//   d_in  [15:0] write data (CPU write data [15:0])
//   cs           chip select from the address decoder
//   addr  [4:0]  byte offset within the peripheral window
//   rd           read strobe
//   wr           write strobe
//   d_out [31:0] read data back to the CPU read-data mux
// master: the CPU side (drives the access); slave: the peripheral.
interface bus_mult16_if;
  logic [15:0] d_in;
  logic        cs;
  logic [4:0]  addr;
  logic        rd;
  logic        wr;
  logic [31:0] d_out;

  modport master (
    output d_in, cs, addr, rd, wr,
    input  d_out
  );

  modport slave (
    input  d_in, cs, addr, rd, wr,
    output d_out
  );
endinterface

// File: rtl/bus_mult16.sv
// bus_mult16: memory-mapped 16x16 -> 32 unsigned shift-add multiplier.
//   clk    system clock, all state changes on the rising edge
//   resetn asynchronous active-low reset
//   bus    slave side of bus_mult16_if (d_in, cs, addr, rd, wr, d_out)
// Register map (byte offset):
//   0x04 A      R/W operand A, zero-extended on read
//   0x08 B      R/W operand B, zero-extended on read
//   0x0C INIT   W   any write starts a multiply (ignored while busy)
//   0x10 STATUS R   bit0 done, bit1 busy
//   0x14 RESULT R   32-bit product
// A multiply takes 16 BUSY edges after the INIT edge; the operands are
// copied at INIT, so A/B may be rewritten while the product is running.
module bus_mult16 (
  input  logic           clk,
  input  logic           resetn,
  bus_mult16_if.slave    bus
);

  localparam logic [4:0] OFF_A      = 5'h04;
  localparam logic [4:0] OFF_B      = 5'h08;
  localparam logic [4:0] OFF_INIT   = 5'h0C;
  localparam logic [4:0] OFF_STATUS = 5'h10;
  localparam logic [4:0] OFF_RESULT = 5'h14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [15:0] reg_a, reg_b;
  logic [15:0] mplier;
  logic [31:0] mcand;
  logic [31:0] acc;
  logic [3:0]  count;

  logic wr_en, wr_a, wr_b, wr_init, start;
  logic busy, done;

  // Reads have no side effects; the strobe is only part of the bus.
  logic unused_rd;
  assign unused_rd = bus.rd;

  assign wr_en   = bus.cs && bus.wr;
  assign wr_a    = wr_en && (bus.addr == OFF_A);
  assign wr_b    = wr_en && (bus.addr == OFF_B);
  assign wr_init = wr_en && (bus.addr == OFF_INIT);
  assign start   = wr_init && (state != BUSY);

  assign busy = (state == BUSY);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (wr_init) state_next = BUSY;
      // count holds the number of iterations already done; the edge that
      // sees 15 performs the 16th iteration and leaves BUSY.
      BUSY:       if (count == 4'd15) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      reg_a  <= '0;
      reg_b  <= '0;
      mplier <= '0;
      mcand  <= '0;
      acc    <= '0;
      count  <= '0;
    end else begin
      if (wr_a) reg_a <= bus.d_in;
      if (wr_b) reg_b <= bus.d_in;
      if (start) begin
        mplier <= reg_a;
        mcand  <= {16'h0000, reg_b};
        acc    <= '0;
        count  <= '0;
      end else if (state == BUSY) begin
        if (mplier[0]) acc <= acc + mcand;
        mplier <= mplier >> 1;
        mcand  <= mcand << 1;
        count  <= count + 4'd1;
      end
    end
  end

  always_comb begin
    bus.d_out = '0;
    if (bus.cs) begin
      case (bus.addr)
        OFF_A:      bus.d_out = {16'h0000, reg_a};
        OFF_B:      bus.d_out = {16'h0000, reg_b};
        OFF_STATUS: bus.d_out = {30'd0, busy, done};
        OFF_RESULT: bus.d_out = acc;
        default:    bus.d_out = '0;
      endcase
    end
  end

endmodule
